seq_fetch_unit: RTL and testbench

// Fetch stage: owns the fetch PC and issues reads to the synchronous instruction ROM (1-cycle read latency).

---
 rtl/seq_fetch_unit.sv | 105 ++++++++++
 tb/tb_seq_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_fetch_unit.sv
// Fetch stage: drives the fetch PC into a 1-cycle synchronous instruction ROM and
// buffers returned words with their PCs in a small prefetch queue for decode.
module seq_fetch_unit #(
    parameter int ADDRESS_SIZE = 10,
    parameter int INSTR_SIZE   = 16,
    parameter int BUF_DEPTH    = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_sys_halt,
    input  logic                    i_stall,
    input  logic                    i_jump,
    input  logic [ADDRESS_SIZE-1:0] i_jump_addr,
    output logic                    o_imem_en,
    output logic [ADDRESS_SIZE-1:0] o_imem_addr,
    input  logic [INSTR_SIZE-1:0]   i_imem_data,
    output logic [INSTR_SIZE-1:0]   o_instruction,
    output logic                    o_instr_valid,
    output logic [ADDRESS_SIZE-1:0] o_pc,
    output logic                    o_flush
);

    localparam int PTRW = $clog2(BUF_DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam int SUMW = CNTW + 1;

    localparam logic [ADDRESS_SIZE-1:0] PC_ONE  = ADDRESS_SIZE'(1);
    localparam logic [PTRW-1:0]         PTR_ONE = PTRW'(1);
    localparam logic [SUMW-1:0]         DEPTH_S = SUMW'(BUF_DEPTH);

    logic [ADDRESS_SIZE-1:0] r_f_pc;
    logic [ADDRESS_SIZE-1:0] r_req_pc;
    logic                    r_pending;
    logic [PTRW-1:0]         r_rd_ptr;
    logic [PTRW-1:0]         r_wr_ptr;
    logic [CNTW-1:0]         r_count;

    logic [INSTR_SIZE-1:0]   r_q_instr [BUF_DEPTH];
    logic [ADDRESS_SIZE-1:0] r_q_pc    [BUF_DEPTH];

    logic                    w_redirect;
    logic                    w_has_data;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_issue;
    logic [SUMW-1:0]         w_demand;

    // Reset gates the request strobes so nothing reaches the ROM while held in reset.
    assign w_redirect = i_rst_n & i_jump & ~i_sys_halt;
    assign w_has_data = (r_count != '0);
    assign w_pop      = w_has_data & ~w_redirect & ~i_stall & ~i_sys_halt;
    assign w_push     = i_rst_n & r_pending & ~w_redirect;

    // Entries held plus the read in flight, less the entry leaving this cycle.
    assign w_demand = SUMW'(r_count) + SUMW'(r_pending) - SUMW'(w_pop);
    assign w_issue  = i_rst_n & ~i_sys_halt & ~w_redirect & (w_demand < DEPTH_S);

    assign o_imem_en   = w_issue | w_redirect;
    assign o_imem_addr = w_redirect ? i_jump_addr : r_f_pc;
    assign o_flush     = w_redirect;

    assign o_instr_valid = w_has_data & ~w_redirect;
    assign o_instruction = o_instr_valid ? r_q_instr[r_rd_ptr] : '0;
    assign o_pc          = o_instr_valid ? r_q_pc[r_rd_ptr]    : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_f_pc    <= '0;
            r_req_pc  <= '0;
            r_pending <= 1'b0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
        end else if (w_redirect) begin
            r_f_pc    <= i_jump_addr + PC_ONE;
            r_req_pc  <= i_jump_addr;
            r_pending <= 1'b1;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_issue;
            if (w_issue) begin
                r_f_pc   <= r_f_pc + PC_ONE;
                r_req_pc <= r_f_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= i_imem_data;
            r_q_pc[r_wr_ptr]    <= r_req_pc;
        end
    end

endmodule

// File: tb/tb_seq_fetch_unit.sv
// Directed bench for seq_fetch_unit: ROM model returns 16'hA000+addr one cycle after a read.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_seq_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_sys_halt = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_jump = 1'b0;
    logic [9:0]  i_jump_addr = '0;
    logic        o_imem_en;
    logic [9:0]  o_imem_addr;
    logic [15:0] i_imem_data;
    logic [15:0] o_instruction;
    logic        o_instr_valid;
    logic [9:0]  o_pc;
    logic        o_flush;

    logic [15:0] rom_q = '0;
    int checks = 0;
    int errors = 0;

    seq_fetch_unit #(.ADDRESS_SIZE(10), .INSTR_SIZE(16), .BUF_DEPTH(2)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_sys_halt   (i_sys_halt),
        .i_stall      (i_stall),
        .i_jump       (i_jump),
        .i_jump_addr  (i_jump_addr),
        .o_imem_en    (o_imem_en),
        .o_imem_addr  (o_imem_addr),
        .i_imem_data  (i_imem_data),
        .o_instruction(o_instruction),
        .o_instr_valid(o_instr_valid),
        .o_pc         (o_pc),
        .o_flush      (o_flush)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_imem_en) rom_q <= 16'hA000 + 16'(o_imem_addr);
    end
    assign i_imem_data = rom_q;

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_instr_valid); end
        checks++; if (o_pc !== 10'h000) begin errors++; $display("FAIL reset_pc got %h want 000", o_pc); end
        checks++; if (o_instruction !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", o_instruction); end
        checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", o_flush); end
        checks++; if (o_imem_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", o_imem_en); end
    endtask

    // Cycle 0 is the first cycle with reset released; head appears at cycle 2.
    task automatic test_stream();
        i_rst_n = 1'b1;
        #1;
        checks++; if (o_imem_en !== 1'b1 || o_imem_addr !== 10'h000) begin errors++; $display("FAIL stream_c0_issue got en=%b addr=%h want en=1 addr=000", o_imem_en, o_imem_addr); end
        checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL stream_c0_valid got %b want 0", o_instr_valid); end
        for (int c = 1; c <= 7; c++) begin
            @(negedge i_clk); #1;
            checks++; if (o_imem_en !== 1'b1 || o_imem_addr !== 10'(c)) begin errors++; $display("FAIL stream_issue c=%0d got en=%b addr=%h want en=1 addr=%h", c, o_imem_en, o_imem_addr, 10'(c)); end
            if (c < 2) begin
                checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL stream_startup c=%0d valid got %b want 0", c, o_instr_valid); end
            end else begin
                checks++; if (o_instr_valid !== 1'b1 || o_pc !== 10'(c - 2) || o_instruction !== 16'hA000 + 16'(c - 2)) begin
                    errors++; $display("FAIL stream_head c=%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", c, o_instr_valid, o_pc, o_instruction, 10'(c - 2), 16'hA000 + 16'(c - 2));
                end
            end
        end
    endtask

    // Enters at cycle 7 (head pc 5, pc 6 in flight).
    task automatic test_stall();
        i_stall = 1'b1;
        #1;
        checks++; if (o_imem_en !== 1'b0 || o_pc !== 10'h005) begin errors++; $display("FAIL stall_enter got en=%b pc=%h want en=0 pc=005", o_imem_en, o_pc); end
        for (int c = 8; c <= 11; c++) begin
            @(negedge i_clk); #1;
            checks++; if (o_imem_en !== 1'b0 || o_instr_valid !== 1'b1 || o_pc !== 10'h005) begin
                errors++; $display("FAIL stall_hold c=%0d got en=%b v=%b pc=%h want en=0 v=1 pc=005", c, o_imem_en, o_instr_valid, o_pc);
            end
        end
        @(negedge i_clk);
        i_stall = 1'b0;
        #1;
        checks++; if (o_pc !== 10'h005 || o_imem_en !== 1'b1 || o_imem_addr !== 10'h007) begin
            errors++; $display("FAIL stall_release got pc=%h en=%b addr=%h want pc=005 en=1 addr=007", o_pc, o_imem_en, o_imem_addr);
        end
        for (int k = 6; k <= 8; k++) begin
            @(negedge i_clk); #1;
            checks++; if (o_instr_valid !== 1'b1 || o_pc !== 10'(k) || o_instruction !== 16'hA000 + 16'(k)) begin
                errors++; $display("FAIL stall_resume got v=%b pc=%h ins=%h want pc=%h", o_instr_valid, o_pc, o_instruction, 10'(k));
            end
        end
    endtask

    // Enters at cycle 15 (head pc 8); a stall cycle fills the queue to 2 before jumping.
    task automatic test_jump();
        i_stall = 1'b1;
        #1;
        checks++; if (o_imem_en !== 1'b0) begin errors++; $display("FAIL jump_fill_en got %b want 0", o_imem_en); end
        @(negedge i_clk); #1;
        checks++; if (o_pc !== 10'h008 || o_imem_en !== 1'b0) begin errors++; $display("FAIL jump_full got pc=%h en=%b want pc=008 en=0", o_pc, o_imem_en); end
        i_stall = 1'b0; i_jump = 1'b1; i_jump_addr = 10'h3FE;
        #1;
        checks++; if (o_flush !== 1'b1 || o_instr_valid !== 1'b0) begin errors++; $display("FAIL jump_flush got flush=%b v=%b want flush=1 v=0", o_flush, o_instr_valid); end
        checks++; if (o_imem_en !== 1'b1 || o_imem_addr !== 10'h3FE) begin errors++; $display("FAIL jump_issue got en=%b addr=%h want en=1 addr=3fe", o_imem_en, o_imem_addr); end
        checks++; if (o_pc !== 10'h000 || o_instruction !== 16'h0000) begin errors++; $display("FAIL jump_nop got pc=%h ins=%h want 000/0000", o_pc, o_instruction); end
        @(negedge i_clk);
        i_jump = 1'b0;
        #1;
        checks++; if (o_flush !== 1'b0 || o_instr_valid !== 1'b0 || o_imem_addr !== 10'h3FF) begin
            errors++; $display("FAIL jump_plus1 got flush=%b v=%b addr=%h want 0 0 3ff", o_flush, o_instr_valid, o_imem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            logic [9:0] exp_pc;
            exp_pc = 10'h3FE + 10'(k);
            @(negedge i_clk); #1;
            checks++; if (o_instr_valid !== 1'b1 || o_pc !== exp_pc || o_instruction !== 16'hA000 + 16'(exp_pc)) begin
                errors++; $display("FAIL jump_target got v=%b pc=%h ins=%h want pc=%h ins=%h", o_instr_valid, o_pc, o_instruction, exp_pc, 16'hA000 + 16'(exp_pc));
            end
        end
    endtask

    // Enters at cycle 20 (pc 002 issued); halt starts the next cycle with 002 in flight.
    task automatic test_halt();
        @(negedge i_clk);
        i_sys_halt = 1'b1;
        #1;
        checks++; if (o_imem_en !== 1'b0 || o_pc !== 10'h001 || o_instr_valid !== 1'b1) begin
            errors++; $display("FAIL halt_enter got en=%b v=%b pc=%h want en=0 v=1 pc=001", o_imem_en, o_instr_valid, o_pc);
        end
        for (int c = 22; c <= 24; c++) begin
            @(negedge i_clk);
            i_jump = (c != 24); i_jump_addr = 10'h155;
            #1;
            checks++; if (o_flush !== 1'b0 || o_imem_en !== 1'b0 || o_pc !== 10'h001 || o_instruction !== 16'hA001) begin
                errors++; $display("FAIL halt_hold c=%0d got flush=%b en=%b pc=%h ins=%h want 0 0 001 a001", c, o_flush, o_imem_en, o_pc, o_instruction);
            end
        end
        @(negedge i_clk);
        i_sys_halt = 1'b0; i_jump = 1'b0;
        #1;
        checks++; if (o_pc !== 10'h001 || o_imem_en !== 1'b1 || o_imem_addr !== 10'h003) begin
            errors++; $display("FAIL halt_release got pc=%h en=%b addr=%h want pc=001 en=1 addr=003", o_pc, o_imem_en, o_imem_addr);
        end
        for (int k = 2; k <= 4; k++) begin
            @(negedge i_clk); #1;
            checks++; if (o_instr_valid !== 1'b1 || o_pc !== 10'(k) || o_instruction !== 16'hA000 + 16'(k)) begin
                errors++; $display("FAIL halt_resume got v=%b pc=%h ins=%h want pc=%h", o_instr_valid, o_pc, o_instruction, 10'(k));
            end
        end
    endtask

    // Enters at cycle 28 (head pc 4). Fill queue to 2, then reset with pc 6 in flight.
    task automatic test_reset_midflight();
        i_stall = 1'b1;
        #1;
        @(negedge i_clk);
        i_stall = 1'b0;
        #1;
        checks++; if (o_pc !== 10'h004 || o_imem_en !== 1'b1 || o_imem_addr !== 10'h006) begin
            errors++; $display("FAIL rst_pre got pc=%h en=%b addr=%h want 004 1 006", o_pc, o_imem_en, o_imem_addr);
        end
        @(negedge i_clk); #1;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_imem_en !== 1'b0) begin errors++; $display("FAIL rst_hold_en got %b want 0", o_imem_en); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        checks++; if (o_instr_valid !== 1'b0 || o_pc !== 10'h000 || o_instruction !== 16'h0000 || o_flush !== 1'b0) begin
            errors++; $display("FAIL rst_mid_out got v=%b pc=%h ins=%h flush=%b want 0 000 0000 0", o_instr_valid, o_pc, o_instruction, o_flush);
        end
        checks++; if (o_imem_en !== 1'b1 || o_imem_addr !== 10'h000) begin errors++; $display("FAIL rst_mid_issue got en=%b addr=%h want 1 000", o_imem_en, o_imem_addr); end
        @(negedge i_clk); #1;
        checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL rst_stale got v=%b ins=%h want v=0", o_instr_valid, o_instruction); end
        @(negedge i_clk); #1;
        checks++; if (o_instr_valid !== 1'b1 || o_pc !== 10'h000 || o_instruction !== 16'hA000) begin
            errors++; $display("FAIL rst_restart got v=%b pc=%h ins=%h want 1 000 a000", o_instr_valid, o_pc, o_instruction);
        end
    endtask

    // Enters at cycle 33 (head pc 0); jump and stall together.
    task automatic test_jump_stall();
        i_stall = 1'b1; i_jump = 1'b1; i_jump_addr = 10'h040;
        #1;
        checks++; if (o_flush !== 1'b1 || o_instr_valid !== 1'b0 || o_imem_en !== 1'b1 || o_imem_addr !== 10'h040) begin
            errors++; $display("FAIL js_jump got flush=%b v=%b en=%b addr=%h want 1 0 1 040", o_flush, o_instr_valid, o_imem_en, o_imem_addr);
        end
        @(negedge i_clk);
        i_jump = 1'b0;
        #1;
        checks++; if (o_instr_valid !== 1'b0 || o_imem_en !== 1'b1 || o_imem_addr !== 10'h041) begin
            errors++; $display("FAIL js_plus1 got v=%b en=%b addr=%h want 0 1 041", o_instr_valid, o_imem_en, o_imem_addr);
        end
        @(negedge i_clk); #1;
        checks++; if (o_instr_valid !== 1'b1 || o_pc !== 10'h040 || o_instruction !== 16'hA040 || o_imem_en !== 1'b0) begin
            errors++; $display("FAIL js_target got v=%b pc=%h ins=%h en=%b want 1 040 a040 0", o_instr_valid, o_pc, o_instruction, o_imem_en);
        end
        @(negedge i_clk); #1;
        checks++; if (o_pc !== 10'h040) begin errors++; $display("FAIL js_hold got pc=%h want 040", o_pc); end
        @(negedge i_clk);
        i_stall = 1'b0;
        #1;
        checks++; if (o_pc !== 10'h040 || o_imem_en !== 1'b1 || o_imem_addr !== 10'h042) begin
            errors++; $display("FAIL js_release got pc=%h en=%b addr=%h want 040 1 042", o_pc, o_imem_en, o_imem_addr);
        end
        @(negedge i_clk); #1;
        checks++; if (o_instr_valid !== 1'b1 || o_pc !== 10'h041 || o_instruction !== 16'hA041) begin
            errors++; $display("FAIL js_next got v=%b pc=%h ins=%h want 1 041 a041", o_instr_valid, o_pc, o_instruction);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jump();
        test_halt();
        test_reset_midflight();
        test_jump_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
